// File: rtl/spc2_pkg.sv
// spc2 configuration sequencer shared definitions.
// Field layout of the spc2 config word and the frame FSM states.
package spc2_pkg;

    localparam int CFG_W = 16;
    localparam int F_W   = 4;
    localparam int GS_W  = 4;
    localparam int GD_W  = 3;

    localparam int F_LSB  = 12;
    localparam int IQ_BIT = 11;
    localparam int GS_LSB = 7;
    localparam int CE_BIT = 6;
    localparam int NS_BIT = 5;
    localparam int GD_LSB = 2;
    localparam int FS_BIT = 1;
    localparam int RE_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_GUARD
    } seq_state_t;

    // Data bit idx of the frame; bit 0 of the frame is the word MSB.
    function automatic logic msb_first(
        input logic [CFG_W-1:0] w,
        input logic [3:0]       idx
    );
        return w[4'(CFG_W - 1) - idx];
    endfunction

endpackage

// File: rtl/spc2_bit_timer.sv
// Baud counter shared by the start, data and guard periods.
// Strobes bit_done on the last clock of every bit period.
module spc2_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_done = en && (cnt_q == CNT_LAST);

    // Free-running within a frame; wraps at each bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || bit_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spc2_cfg_sequencer.sv
// Serializes 16-bit spc2 config words into framed Cfg_in bitstreams.
// One pending word is buffered; the last word can be refreshed.
module spc2_cfg_sequencer
    import spc2_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 4,
    parameter int GUARD_BITS     = 2,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             refresh_en,
    output logic             Cfg_out,
    output logic             busy,
    output logic             done,
    output logic [CFG_W-1:0] active_cfg,
    output logic             active_valid
);

    localparam int GW = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [GW-1:0] GRD_LAST = GW'(GUARD_BITS - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [CFG_W-1:0] word_q, word_d;
    logic [CFG_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    grd_q, grd_d;
    logic             out_q, out_d;
    logic [CFG_W-1:0] act_q, act_d;
    logic             act_v_q, act_v_d;
    logic [TW-1:0]    tmr_q, tmr_d;

    logic bit_done;
    logic hs;
    logic grd_last;
    logic tmr_run;
    logic rfr_trig;

    spc2_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (Clk),
        .rst_n   (Resetn),
        .en      (state_q != ST_IDLE),
        .bit_done(bit_done)
    );

    assign cfg_ready    = !pend_v_q;
    assign hs           = cfg_valid && cfg_ready;
    assign busy         = (state_q != ST_IDLE);
    assign grd_last     = (state_q == ST_GUARD) && bit_done
                       && (grd_q == GRD_LAST);
    assign done         = grd_last;
    assign Cfg_out      = out_q;
    assign active_cfg   = act_q;
    assign active_valid = act_v_q;

    assign tmr_run  = (state_q == ST_IDLE) && refresh_en && act_v_q;
    assign rfr_trig = tmr_run && (tmr_q == TMR_LAST);

    // Refresh timer: idle cycles since the last frame, host word wins.
    always_comb begin
        tmr_d = '0;
        if (tmr_run && !rfr_trig && !hs) begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    // Frame FSM: next state, registered serial bit, buffers.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        bit_cnt_d = bit_cnt_q;
        grd_d     = grd_q;
        out_d     = out_q;
        act_d     = act_q;
        act_v_d   = act_v_q;

        if (hs && busy && !grd_last) begin
            pend_d   = cfg_data;
            pend_v_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d = ST_START;
                    word_d  = cfg_data;
                    out_d   = 1'b1;
                end else if (rfr_trig) begin
                    state_d = ST_START;
                    word_d  = act_q;
                    out_d   = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    out_d     = msb_first(word_q, 4'd0);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 4'd15) begin
                        state_d = ST_GUARD;
                        grd_d   = '0;
                        out_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        out_d     = msb_first(word_q, bit_cnt_q + 4'd1);
                    end
                end
            end
            ST_GUARD: begin
                if (grd_last) begin
                    act_d   = word_q;
                    act_v_d = 1'b1;
                    if (pend_v_q) begin
                        state_d  = ST_START;
                        word_d   = pend_q;
                        pend_v_d = 1'b0;
                        out_d    = 1'b1;
                    end else if (hs) begin
                        state_d = ST_START;
                        word_d  = cfg_data;
                        out_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        out_d   = 1'b0;
                    end
                end else if (bit_done) begin
                    grd_d = grd_q + GW'(1);
                end
            end
        endcase
    end

    // State and datapath registers; reset truncates any frame.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            bit_cnt_q <= '0;
            grd_q     <= '0;
            out_q     <= 1'b0;
            act_q     <= '0;
            act_v_q   <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            bit_cnt_q <= bit_cnt_d;
            grd_q     <= grd_d;
            out_q     <= out_d;
            act_q     <= act_d;
            act_v_q   <= act_v_d;
            tmr_q     <= tmr_d;
        end
    end

endmodule

// File: tb/tb_spc2_cfg_sequencer.sv
// Bench for spc2_cfg_sequencer: waveform-queue model plus directed pins.
// Model and DUT are compared on every falling clock edge.
module tb_spc2_cfg_sequencer;

    localparam int CPB = 4;
    localparam int GB  = 2;
    localparam int RC  = 50;

    logic        Clk = 1'b0;
    logic        Resetn = 1'b1;
    logic [15:0] cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        refresh_en = 1'b0;
    logic        Cfg_out;
    logic        busy;
    logic        done;
    logic [15:0] active_cfg;
    logic        active_valid;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    spc2_cfg_sequencer #(
        .CLKS_PER_BIT  (CPB),
        .GUARD_BITS    (GB),
        .REFRESH_CYCLES(RC)
    ) dut (
        .Clk         (Clk),
        .Resetn      (Resetn),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .refresh_en  (refresh_en),
        .Cfg_out     (Cfg_out),
        .busy        (busy),
        .done        (done),
        .active_cfg  (active_cfg),
        .active_valid(active_valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: remaining frame waveform as one bit per clock.
    bit          fq[$];
    logic [15:0] m_cur = '0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_act = '0;
    bit          m_pv = 1'b0;
    bit          m_av = 1'b0;
    int          m_tmr = 0;

    function automatic void m_start(input logic [15:0] w);
        fq.delete();
        for (int c = 0; c < CPB; c++) fq.push_back(1'b1);
        for (int i = 15; i >= 0; i--)
            for (int c = 0; c < CPB; c++) fq.push_back(w[i]);
        for (int c = 0; c < GB * CPB; c++) fq.push_back(1'b0);
        m_cur = w;
        m_tmr = 0;
    endfunction

    function automatic void m_reset();
        fq.delete();
        m_pv = 1'b0;
        m_av = 1'b0;
        m_act = '0;
        m_tmr = 0;
    endfunction

    function automatic void m_step();
        bit h;
        h = cfg_valid && !m_pv;
        if (fq.size() == 1) begin
            void'(fq.pop_front());
            m_act = m_cur;
            m_av = 1'b1;
            if (m_pv) begin
                m_pv = 1'b0;
                m_start(m_pend);
            end else if (h) begin
                m_start(cfg_data);
            end
        end else if (fq.size() > 1) begin
            void'(fq.pop_front());
            if (h) begin
                m_pend = cfg_data;
                m_pv = 1'b1;
            end
        end else if (h) begin
            m_start(cfg_data);
        end else if (refresh_en && m_av) begin
            if (m_tmr == RC - 1) m_start(m_act);
            else m_tmr++;
        end else begin
            m_tmr = 0;
        end
    endfunction

    initial forever begin
        @(posedge Clk or negedge Resetn);
        if (!Resetn) m_reset();
        else m_step();
    end

    bit e_busy, e_out, e_done;

    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            e_busy = fq.size() > 0;
            e_out  = e_busy ? fq[0] : 1'b0;
            e_done = fq.size() == 1;
            chk("cmp_Cfg_out", 32'(Cfg_out), 32'(e_out));
            chk("cmp_busy", 32'(busy), 32'(e_busy));
            chk("cmp_done", 32'(done), 32'(e_done));
            chk("cmp_cfg_ready", 32'(cfg_ready), 32'(!m_pv));
            chk("cmp_active_cfg", 32'(active_cfg), 32'(m_act));
            chk("cmp_active_valid", 32'(active_valid), 32'(m_av));
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk({nm, "_idle_timeout"}, 32'(busy), 32'(0));
    endtask

    int   nd, last_d, gap, hi, cyc_to;
    logic prev, at20, at21;

    initial begin
        #1 Resetn = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_Cfg_out", 32'(Cfg_out), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("rst_active_cfg", 32'(active_cfg), 32'(0));
        chk("rst_active_valid", 32'(active_valid), 32'(0));
        Resetn = 1'b1;
        chk_en = 1'b1;
        @(negedge Clk);

        // A5C3, then 0001 during the frame, then 1234 held at GUARD end.
        cfg_data = 16'hA5C3;
        cfg_valid = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            @(negedge Clk);
            case (k)
                1:   chk("a5_start_k1", 32'(Cfg_out), 32'(1));
                4:   chk("a5_start_k4", 32'(Cfg_out), 32'(1));
                5:   chk("a5_bit15", 32'(Cfg_out), 32'(1));
                9:   chk("a5_bit14", 32'(Cfg_out), 32'(0));
                13:  chk("a5_bit13", 32'(Cfg_out), 32'(1));
                68:  chk("a5_bit0", 32'(Cfg_out), 32'(1));
                69:  chk("a5_guard", 32'(Cfg_out), 32'(0));
                75:  chk("a5_done_k75", 32'(done), 32'(0));
                76: begin
                    chk("a5_done_k76", 32'(done), 32'(1));
                    chk("a5_ready_k76", 32'(cfg_ready), 32'(0));
                end
                77: begin
                    chk("a5_active", 32'(active_cfg), 32'(16'hA5C3));
                    chk("b_start_k77", 32'(Cfg_out), 32'(1));
                    chk("a5_ready_k77", 32'(cfg_ready), 32'(1));
                end
                78:  chk("c_ready_k78", 32'(cfg_ready), 32'(0));
                140: chk("b_bit1", 32'(Cfg_out), 32'(0));
                141: chk("b_bit0", 32'(Cfg_out), 32'(1));
                152: chk("b_done_k152", 32'(done), 32'(1));
                153: begin
                    chk("b_active", 32'(active_cfg), 32'(16'h0001));
                    chk("c_start_k153", 32'(Cfg_out), 32'(1));
                end
                229: begin
                    chk("c_active", 32'(active_cfg), 32'(16'h1234));
                    chk("c_idle", 32'(busy), 32'(0));
                end
                default: ;
            endcase
            cfg_valid = 1'b0;
            cfg_data = 16'($urandom);
            if (k == 10) begin
                cfg_valid = 1'b1;
                cfg_data = 16'h0001;
            end
            if (k >= 70 && k <= 77) begin
                cfg_valid = 1'b1;
                cfg_data = 16'h1234;
            end
        end

        // Periodic refresh with no host traffic.
        refresh_en = 1'b1;
        nd = 0;
        last_d = 0;
        gap = 0;
        prev = Cfg_out;
        for (int t = 1; t <= 300; t++) begin
            @(negedge Clk);
            if (done) begin
                nd++;
                last_d = t;
            end
            if (Cfg_out && !prev && last_d > 0 && gap == 0)
                gap = t - last_d;
            prev = Cfg_out;
        end
        chk("rfr_done_count", 32'(nd), 32'(2));
        chk("rfr_gap", 32'(gap), 32'(51));
        chk("rfr_active", 32'(active_cfg), 32'(16'h1234));

        // Host word on the same cycle the refresh would fire.
        cyc_to = 0;
        while (!(fq.size() == 0 && m_tmr == RC - 1) && cyc_to < 400) begin
            @(negedge Clk);
            cyc_to++;
        end
        chk("col_wait_timeout", 32'(cyc_to < 400), 32'(1));
        cfg_valid = 1'b1;
        cfg_data = 16'h5A5A;
        for (int k = 1; k <= 77; k++) begin
            @(negedge Clk);
            cfg_valid = 1'b0;
            if (k == 1) chk("col_start", 32'(Cfg_out), 32'(1));
            if (k == 9) chk("col_bit14", 32'(Cfg_out), 32'(1));
        end
        chk("col_active", 32'(active_cfg), 32'(16'h5A5A));
        refresh_en = 1'b0;
        wait_idle("col");

        // F field only: exactly the first four data bits high.
        @(negedge Clk);
        cfg_valid = 1'b1;
        cfg_data = 16'hF000;
        hi = 0;
        at20 = 1'b0;
        at21 = 1'b1;
        for (int k = 1; k <= 77; k++) begin
            @(negedge Clk);
            cfg_valid = 1'b0;
            if (k <= 76 && Cfg_out) hi++;
            if (k == 20) at20 = Cfg_out;
            if (k == 21) at21 = Cfg_out;
        end
        chk("f_high_cycles", 32'(hi), 32'(20));
        chk("f_k20", 32'(at20), 32'(1));
        chk("f_k21", 32'(at21), 32'(0));
        chk("f_active", 32'(active_cfg), 32'(16'hF000));
        wait_idle("f");

        // Reset at cycle 30 of a frame with a word pending.
        @(negedge Clk);
        cfg_valid = 1'b1;
        cfg_data = 16'hFFFF;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            cfg_valid = (k == 5);
            cfg_data = 16'h7777;
        end
        chk("mr_pre_out", 32'(Cfg_out), 32'(1));
        #1 Resetn = 1'b0;
        #1;
        chk("mr_Cfg_out", 32'(Cfg_out), 32'(0));
        chk("mr_busy", 32'(busy), 32'(0));
        chk("mr_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("mr_active_valid", 32'(active_valid), 32'(0));
        repeat (3) @(negedge Clk);
        Resetn = 1'b1;
        nd = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (done) nd++;
        end
        chk("mr_no_done", 32'(nd), 32'(0));
        chk("mr_ready_after", 32'(cfg_ready), 32'(1));

        // Random traffic and refresh toggling.
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_data = 16'($urandom);
            if ($urandom_range(0, 199) == 0) refresh_en = ~refresh_en;
        end
        cfg_valid = 1'b0;
        @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
